// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcode sequencer: walks next_adr_rom chains per bytecode
// and streams each micro-op address; ROM illegal marks and runaway chains trap sticky.
module ucode_sequencer #(
  parameter int ADR_W     = 9,
  parameter int OP_W      = 8,
  parameter int MAX_STEPS = 16,
  parameter logic [ADR_W-1:0] ILL_ADR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bc_valid,
  input  logic [OP_W-1:0]  bc_opcode,
  output logic             bc_ready,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [ADR_W-1:0] rom_next,
  output logic             uop_valid,
  output logic [ADR_W-1:0] uop_adr,
  output logic             uop_last,
  input  logic             uop_ready,
  output logic             busy,
  output logic             err,
  output logic [ADR_W-1:0] err_adr,
  output logic [1:0]       err_code
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADR_W-1:0]  cur;
  logic [STEP_W-1:0] step;

  logic accept, fire, chain_end, chain_ill, chain_runaway;

  assign accept        = (state == S_IDLE) && bc_valid && !rst;
  assign fire          = (state == S_ISSUE) && uop_ready;
  assign chain_end     = (rom_next == '0);
  assign chain_ill     = (rom_next == ILL_ADR);
  assign chain_runaway = (step == STEP_MAX);

  // State register plus the datapath that moves with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      step     <= '0;
      err_adr  <= '0;
      err_code <= 2'b00;
    end else begin
      state <= state_nx;
      if (accept) begin
        cur  <= ADR_W'(bc_opcode);
        step <= STEP_W'(1);
      end else if (fire && !chain_end) begin
        if (chain_ill) begin
          err_adr  <= cur;
          err_code <= 2'b01;
        end else if (chain_runaway) begin
          err_adr  <= cur;
          err_code <= 2'b10;
        end else begin
          cur  <= rom_next;
          step <= step + STEP_W'(1);
        end
      end
    end
  end

  // Terminator wins over the illegal marker, which wins over the step limit.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ISSUE;
      S_ISSUE: if (fire) begin
        if (chain_end)                      state_nx = S_IDLE;
        else if (chain_ill || chain_runaway) state_nx = S_ERR;
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bc_ready  = (state == S_IDLE) && !rst;
    rom_adr   = cur;
    uop_adr   = cur;
    uop_valid = (state == S_ISSUE);
    uop_last  = (state == S_ISSUE) && chain_end;
    busy      = (state == S_ISSUE);
    err       = (state == S_ERR);
  end

endmodule
